// File: rtl/div_issue_if.sv
`timescale 1ns/1ps
// EXE request/response and divider start/finish handshakes seen by div_issue_ctrl.
// slave: the controller's view; master: the environment (EXE stage plus divider core).
interface div_issue_if #(
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_signed;
  logic [DW-1:0] req_a;
  logic [DW-1:0] req_b;
  logic          req_retire;
  logic          resp_valid;
  logic [DW-1:0] resp_q;
  logic [DW-1:0] resp_r;
  logic          div_start_valid_o;
  logic          div_start_ready_i;
  logic          div_signed_o;
  logic [DW-1:0] div_dividend_o;
  logic [DW-1:0] div_divisor_o;
  logic          div_finish_valid_i;
  logic          div_finish_ready_o;
  logic [DW-1:0] div_quotient_i;
  logic [DW-1:0] div_remainder_i;

  modport slave (
    input  req_valid, req_signed, req_a, req_b, req_retire,
    input  div_start_ready_i, div_finish_valid_i, div_quotient_i, div_remainder_i,
    output resp_valid, resp_q, resp_r,
    output div_start_valid_o, div_signed_o, div_dividend_o, div_divisor_o, div_finish_ready_o
  );

  modport master (
    output req_valid, req_signed, req_a, req_b, req_retire,
    output div_start_ready_i, div_finish_valid_i, div_quotient_i, div_remainder_i,
    input  resp_valid, resp_q, resp_r,
    input  div_start_valid_o, div_signed_o, div_dividend_o, div_divisor_o, div_finish_ready_o
  );
endinterface

// File: rtl/div_issue_ctrl.sv
`timescale 1ns/1ps
// Sequences the shared radix-4 divider for EXE: operand latch, start/finish handshakes,
// result hold until retire, silent drain on flush, and a one-entry reuse buffer.
module div_issue_ctrl #(
  parameter int          DW          = 32,
  parameter logic [31:0] DIV_CNT_RST = 32'd0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  div_issue_if.slave  bus,
  output logic        busy,
  output logic [31:0] div_cnt,
  output logic [31:0] hit_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic          op_signed_r;
  logic [DW-1:0] op_a_r;
  logic [DW-1:0] op_b_r;
  logic          buf_valid_r;
  logic          buf_signed_r;
  logic [DW-1:0] buf_a_r;
  logic [DW-1:0] buf_b_r;
  logic [DW-1:0] buf_q_r;
  logic [DW-1:0] buf_rem_r;
  logic [31:0]   div_cnt_r;
  logic [31:0]   hit_cnt_r;
  logic          hit_s;
  logic          latch_s;
  logic          buf_wr_s;
  logic          hit_inc_s;

  assign hit_s = buf_valid_r && (buf_signed_r == bus.req_signed) &&
                 (buf_a_r == bus.req_a) && (buf_b_r == bus.req_b);

  // Next-state decode; flush outranks request and retire in every state.
  always_comb begin
    state_s   = state_r;
    latch_s   = 1'b0;
    buf_wr_s  = 1'b0;
    hit_inc_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.req_valid && !flush) begin
          if (hit_s) begin
            state_s   = S_DONE;
            hit_inc_s = 1'b1;
          end else begin
            state_s = S_ISSUE;
            latch_s = 1'b1;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (bus.div_start_ready_i) begin
          state_s = flush ? S_DRAIN : S_WAIT;
        end else if (flush) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (bus.div_finish_valid_i) begin
          buf_wr_s = 1'b1;
          state_s  = flush ? S_IDLE : S_DONE;
        end else if (flush) begin
          state_s = S_DRAIN;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_DONE: begin
        if (bus.req_retire || flush) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DONE;
        end
      end
      S_DRAIN: begin
        if (bus.div_finish_valid_i) begin
          buf_wr_s = 1'b1;
          state_s  = S_IDLE;
        end else begin
          state_s = S_DRAIN;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State, operand, reuse-buffer and counter registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r      <= S_IDLE;
      op_signed_r  <= 1'b0;
      op_a_r       <= '0;
      op_b_r       <= '0;
      buf_valid_r  <= 1'b0;
      buf_signed_r <= 1'b0;
      buf_a_r      <= '0;
      buf_b_r      <= '0;
      buf_q_r      <= '0;
      buf_rem_r    <= '0;
      div_cnt_r    <= DIV_CNT_RST;
      hit_cnt_r    <= 32'd0;
    end else begin
      state_r <= state_s;
      if (latch_s) begin
        op_signed_r <= bus.req_signed;
        op_a_r      <= bus.req_a;
        op_b_r      <= bus.req_b;
      end
      // Drained results are tagged with their own operands, so they stay reusable.
      if (buf_wr_s) begin
        buf_valid_r  <= 1'b1;
        buf_signed_r <= op_signed_r;
        buf_a_r      <= op_a_r;
        buf_b_r      <= op_b_r;
        buf_q_r      <= bus.div_quotient_i;
        buf_rem_r    <= bus.div_remainder_i;
        div_cnt_r    <= div_cnt_r + 32'd1;
      end
      if (hit_inc_s) begin
        hit_cnt_r <= hit_cnt_r + 32'd1;
      end
    end
  end

  assign busy                   = (state_r != S_IDLE);
  assign bus.resp_valid         = (state_r == S_DONE);
  assign bus.resp_q             = buf_q_r;
  assign bus.resp_r             = buf_rem_r;
  assign bus.div_start_valid_o  = (state_r == S_ISSUE);
  assign bus.div_signed_o       = op_signed_r;
  assign bus.div_dividend_o     = op_a_r;
  assign bus.div_divisor_o      = op_b_r;
  assign bus.div_finish_ready_o = (state_r == S_WAIT) || (state_r == S_DRAIN);
  assign div_cnt                = div_cnt_r;
  assign hit_cnt                = hit_cnt_r;

endmodule

// File: tb/tb_div_issue_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for div_issue_ctrl: behavioural divider core plus a reference
// model of the reuse buffer and counters; a second instance checks div_cnt wrap.
module tb_div_issue_ctrl;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic resetn;
  logic flush;
  always #5 clk = ~clk;

  div_issue_if #(.DW(DW)) bus ();
  logic        busy;
  logic [31:0] div_cnt, hit_cnt;
  div_issue_ctrl #(.DW(DW)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .bus(bus),
    .busy(busy), .div_cnt(div_cnt), .hit_cnt(hit_cnt)
  );

  div_issue_if #(.DW(DW)) wbus ();
  logic        w_busy;
  logic [31:0] w_div_cnt, w_hit_cnt;
  div_issue_ctrl #(.DW(DW), .DIV_CNT_RST(32'hFFFF_FFFF)) dut_w (
    .clk(clk), .resetn(resetn), .flush(1'b0), .bus(wbus),
    .busy(w_busy), .div_cnt(w_div_cnt), .hit_cnt(w_hit_cnt)
  );
  assign wbus.div_start_ready_i  = 1'b1;
  assign wbus.div_finish_valid_i = 1'b1;
  assign wbus.div_quotient_i     = 32'h0000_0005;
  assign wbus.div_remainder_i    = 32'h0000_0006;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: reuse buffer contents and counters
  logic        m_valid;
  logic        m_s;
  logic [31:0] m_a, m_b;
  logic [31:0] m_div, m_hit;

  // Divider results as the core defines them; /0 gives q=all-ones, r=dividend.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (s) begin
      q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
    end else begin
      q = a / b; r = a % b;
    end
    return {q, r};
  endfunction

  // behavioural divider core: fixed latency from start handshake to finish_valid
  int          lat = 4;
  logic        hold_start = 1'b0;
  logic        dv_busy = 1'b0;
  int          dv_cnt = 0;
  logic [63:0] dv_res = 64'd0;
  int          start_cnt = 0;
  assign bus.div_start_ready_i  = !dv_busy && !hold_start;
  assign bus.div_finish_valid_i = dv_busy && (dv_cnt == 0);
  assign bus.div_quotient_i     = dv_res[63:32];
  assign bus.div_remainder_i    = dv_res[31:0];

  always @(posedge clk) begin
    if (!resetn) begin
      dv_busy <= 1'b0;
    end else if (!dv_busy) begin
      if (bus.div_start_valid_o && bus.div_start_ready_i) begin
        dv_busy <= 1'b1;
        dv_cnt  <= lat - 1;
        dv_res  <= ref_div(bus.div_signed_o, bus.div_dividend_o, bus.div_divisor_o);
      end
    end else if (dv_cnt != 0) begin
      dv_cnt <= dv_cnt - 1;
    end else if (bus.div_finish_ready_o) begin
      dv_busy <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (resetn && bus.div_start_valid_o && bus.div_start_ready_i) start_cnt <= start_cnt + 1;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic model_clear();
    m_valid = 1'b0; m_s = 1'b0; m_a = 32'd0; m_b = 32'd0; m_div = 32'd0; m_hit = 32'd0;
  endtask

  task automatic model_fill(input logic s, input logic [31:0] a, input logic [31:0] b);
    m_valid = 1'b1; m_s = s; m_a = a; m_b = b; m_div = m_div + 32'd1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; flush = 1'b0;
    bus.req_valid = 1'b0; bus.req_signed = 1'b0; bus.req_a = 32'd0; bus.req_b = 32'd0; bus.req_retire = 1'b0;
    wbus.req_valid = 1'b0; wbus.req_signed = 1'b0; wbus.req_a = 32'd0; wbus.req_b = 32'd0; wbus.req_retire = 1'b0;
    model_clear();
    repeat (3) tick();
    n_cmp++;
    if ({busy, bus.resp_valid, bus.div_start_valid_o, bus.div_finish_ready_o} !== 4'b0000 ||
        div_cnt !== 32'd0 || hit_cnt !== 32'd0 || bus.resp_q !== 32'd0 || bus.resp_r !== 32'd0 ||
        bus.div_dividend_o !== 32'd0 || bus.div_divisor_o !== 32'd0 || bus.div_signed_o !== 1'b0) begin
      $display("FAIL reset_state: busy=%b rv=%b sv=%b fr=%b div_cnt=%0d hit_cnt=%0d q=%h r=%h, want all zero",
               busy, bus.resp_valid, bus.div_start_valid_o, bus.div_finish_ready_o, div_cnt, hit_cnt,
               bus.resp_q, bus.resp_r);
      n_bad++;
    end
    resetn = 1'b1;
    tick();
  endtask

  // Run one op to completion and retire it (with flush too when fl_retire).
  task automatic run_op(input string nm, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic fl_retire);
    logic        exp_hit;
    logic [63:0] e;
    int          n, st0, want_lat;
    exp_hit  = m_valid && (m_s == s) && (m_a == a) && (m_b == b);
    e        = ref_div(s, a, b);
    st0      = start_cnt;
    lat      = $urandom_range(12, 1);
    want_lat = exp_hit ? 1 : lat + 2;
    bus.req_signed = s; bus.req_a = a; bus.req_b = b; bus.req_valid = 1'b1;
    n = 0;
    do begin
      tick(); n++;
    end while (!bus.resp_valid && n < 100);
    n_cmp++;
    if (bus.resp_valid !== 1'b1) begin
      $display("FAIL %s timeout: resp_valid=%b after %0d cycles, want 1", nm, bus.resp_valid, n); n_bad++;
    end
    n_cmp++;
    if (n != want_lat) begin
      $display("FAIL %s latency: got %0d want %0d", nm, n, want_lat); n_bad++;
    end
    n_cmp++;
    if ({bus.resp_q, bus.resp_r} !== e) begin
      $display("FAIL %s result: got q=%h r=%h want q=%h r=%h", nm, bus.resp_q, bus.resp_r, e[63:32], e[31:0]);
      n_bad++;
    end
    n_cmp++;
    if (start_cnt - st0 != (exp_hit ? 0 : 1)) begin
      $display("FAIL %s starts: got %0d want %0d", nm, start_cnt - st0, exp_hit ? 0 : 1); n_bad++;
    end
    if (exp_hit) m_hit = m_hit + 32'd1;
    else model_fill(s, a, b);
    n_cmp++;
    if (div_cnt !== m_div || hit_cnt !== m_hit) begin
      $display("FAIL %s counters: got div=%0d hit=%0d want div=%0d hit=%0d", nm, div_cnt, hit_cnt, m_div, m_hit);
      n_bad++;
    end
    bus.req_retire = 1'b1; flush = fl_retire;
    tick();
    bus.req_valid = 1'b0; bus.req_retire = 1'b0; flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || bus.resp_valid !== 1'b0) begin
      $display("FAIL %s retire: busy=%b resp_valid=%b want 0 0", nm, busy, bus.resp_valid); n_bad++;
    end
  endtask

  // Wait out a drain; resp_valid and start_valid must stay low throughout.
  task automatic wait_drain(input string nm);
    int n;
    int seen;
    n = 0; seen = 0;
    while (busy && n < 40) begin
      if (bus.resp_valid || bus.div_start_valid_o) seen++;
      tick(); n++;
    end
    n_cmp++;
    if (busy !== 1'b0 || seen != 0) begin
      $display("FAIL %s drain: busy=%b spurious_cycles=%0d want 0 0", nm, busy, seen); n_bad++;
    end
  endtask

  task automatic test_basic();
    run_op("signed_7_div_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
    run_op("repeat_hit", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
    run_op("unsigned_miss", 1'b0, 32'd7, 32'hFFFF_FFFE, 1'b0);
  endtask

  task automatic test_flush_wait();
    logic [31:0] a, b;
    int          seen, dc0;
    a = $urandom; b = $urandom | 32'd1; lat = 9; dc0 = start_cnt;
    bus.req_signed = 1'b0; bus.req_a = a; bus.req_b = b; bus.req_valid = 1'b1;
    tick(); tick();
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; bus.req_valid = 1'b0;
    n_cmp++;
    if ({busy, bus.resp_valid, bus.div_finish_ready_o} !== 3'b101) begin
      $display("FAIL flush_wait_drain: busy/rv/fr=%b want 101", {busy, bus.resp_valid, bus.div_finish_ready_o});
      n_bad++;
    end
    bus.req_signed = 1'b1; bus.req_a = 32'd100; bus.req_b = 32'd3; bus.req_valid = 1'b1;
    seen = 0;
    repeat (2) begin
      tick();
      if (bus.resp_valid || bus.div_start_valid_o) seen++;
    end
    bus.req_valid = 1'b0;
    n_cmp++;
    if (seen != 0 || start_cnt - dc0 != 1) begin
      $display("FAIL drain_ignores_req: spurious=%0d starts=%0d want 0 1", seen, start_cnt - dc0); n_bad++;
    end
    wait_drain("flush_wait");
    model_fill(1'b0, a, b);
    n_cmp++;
    if (div_cnt !== m_div) begin
      $display("FAIL flush_wait_div_cnt: got %0d want %0d", div_cnt, m_div); n_bad++;
    end
    run_op("drained_reuse", 1'b0, a, b, 1'b0);
  endtask

  task automatic test_flush_issue();
    int st0;
    st0 = start_cnt; lat = 5;
    bus.req_signed = 1'b1; bus.req_a = 32'hFFFF_FF9C; bus.req_b = 32'd7; bus.req_valid = 1'b1;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; bus.req_valid = 1'b0;
    n_cmp++;
    if ({busy, bus.div_finish_ready_o} !== 2'b11 || start_cnt - st0 != 1) begin
      $display("FAIL flush_issue_ready: busy/fr=%b starts=%0d want 11 1", {busy, bus.div_finish_ready_o},
               start_cnt - st0);
      n_bad++;
    end
    wait_drain("flush_issue");
    model_fill(1'b1, 32'hFFFF_FF9C, 32'd7);
    n_cmp++;
    if (div_cnt !== m_div) begin
      $display("FAIL flush_issue_div_cnt: got %0d want %0d", div_cnt, m_div); n_bad++;
    end
    hold_start = 1'b1; st0 = start_cnt;
    bus.req_signed = 1'b0; bus.req_a = 32'd1000; bus.req_b = 32'd9; bus.req_valid = 1'b1;
    tick();
    n_cmp++;
    if (bus.div_start_valid_o !== 1'b1) begin
      $display("FAIL issue_start_valid: got %b want 1", bus.div_start_valid_o); n_bad++;
    end
    flush = 1'b1;
    tick();
    flush = 1'b0; bus.req_valid = 1'b0; hold_start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || bus.div_start_valid_o !== 1'b0 || start_cnt != st0 || div_cnt !== m_div) begin
      $display("FAIL flush_issue_noready: busy=%b sv=%b starts=%0d div_cnt=%0d want 0 0 0 %0d",
               busy, bus.div_start_valid_o, start_cnt - st0, div_cnt, m_div);
      n_bad++;
    end
    run_op("after_abort_miss", 1'b0, 32'd1000, 32'd9, 1'b0);
  endtask

  task automatic test_flush_done_and_reset();
    run_op("flush_retire", 1'b0, 32'h1234_5678, 32'd77, 1'b1);
    run_op("kept_after_flush", 1'b0, 32'h1234_5678, 32'd77, 1'b0);
    lat = 9;
    bus.req_signed = 1'b1; bus.req_a = 32'd55; bus.req_b = 32'd4; bus.req_valid = 1'b1;
    repeat (3) tick();
    resetn = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || bus.resp_valid !== 1'b0 || bus.div_start_valid_o !== 1'b0 ||
        div_cnt !== 32'd0 || hit_cnt !== 32'd0) begin
      $display("FAIL reset_in_wait: busy=%b rv=%b sv=%b div=%0d hit=%0d want 0 0 0 0 0",
               busy, bus.resp_valid, bus.div_start_valid_o, div_cnt, hit_cnt);
      n_bad++;
    end
    resetn = 1'b1;
    model_clear();
    tick();
    run_op("miss_after_reset", 1'b0, 32'h1234_5678, 32'd77, 1'b0);
  endtask

  task automatic test_special();
    logic [31:0] x;
    x = $urandom;
    run_op("ovf_signed", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("ovf_hit", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("udiv_zero", 1'b0, x, 32'd0, 1'b0);
    run_op("sdiv_zero", 1'b1, x, 32'd0, 1'b0);
    run_op("sdiv_zero_hit", 1'b1, x, 32'd0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] pa [4];
    logic [31:0] pb [4];
    int k;
    for (int i = 0; i < 4; i++) begin
      pa[i] = $urandom;
      pb[i] = (i == 3) ? 32'd0 : $urandom_range(40, 1);
    end
    for (int i = 0; i < 24; i++) begin
      k = $urandom_range(3, 0);
      run_op("random", 1'($urandom_range(1, 0)), pa[k], pb[k], 1'($urandom_range(1, 0)));
    end
  endtask

  task automatic test_wrap();
    int n;
    n_cmp++;
    if (w_div_cnt !== 32'hFFFF_FFFF) begin
      $display("FAIL wrap_preload: got %h want ffffffff", w_div_cnt); n_bad++;
    end
    wbus.req_signed = 1'b0; wbus.req_a = 32'd9; wbus.req_b = 32'd2; wbus.req_valid = 1'b1;
    n = 0;
    do begin
      tick(); n++;
    end while (!wbus.resp_valid && n < 20);
    n_cmp++;
    if (wbus.resp_valid !== 1'b1 || w_div_cnt !== 32'd0 || wbus.resp_q !== 32'd5 || wbus.resp_r !== 32'd6) begin
      $display("FAIL wrap_count: rv=%b div_cnt=%h q=%h r=%h want 1 00000000 5 6",
               wbus.resp_valid, w_div_cnt, wbus.resp_q, wbus.resp_r);
      n_bad++;
    end
    wbus.req_retire = 1'b1;
    tick();
    wbus.req_valid = 1'b0; wbus.req_retire = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flush_wait();
    test_flush_issue();
    test_flush_done_and_reset();
    test_special();
    test_random();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
